// File: rtl/pipe_phase_rst_gen.sv
// pipe_phase_rst_gen: phase-enable and core-reset sequencer with run watchdog.
// Optional build macro: PIPE_PHASE_ROUND_CNT_EN (enables the round_cnt counter).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   hold       in   freeze phase sequence, enables forced low
//   halt_req   in   core halt request, ends the run
//   core_rst_n out  synchronised, stretched active-low core reset
//   ph_en      out  one-hot-or-zero registered phase enables
//   phase_idx  out  index of the current/last phase
//   cycle_cnt  out  active cycles since core_rst_n rose
//   done       out  sticky run-finished flag
//   timeout    out  sticky watchdog flag
//   round_cnt  out  completed full phase rounds (0 unless macro defined)
module pipe_phase_rst_gen #(
    parameter int NUM_PHASES  = 2,
    parameter int PHASE_LEN   = 4,
    parameter int GAP_LEN     = 1,
    parameter int RST_STRETCH = 4,
    parameter int TIMEOUT     = 100,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  halt_req,
    output logic                  core_rst_n,
    output logic [NUM_PHASES-1:0] ph_en,
    output logic [((NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1)-1:0] phase_idx,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      round_cnt
);

    localparam int PW    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int MAXA  = (PHASE_LEN > GAP_LEN) ? PHASE_LEN : GAP_LEN;
    localparam int MAXL  = (MAXA > RST_STRETCH) ? MAXA : RST_STRETCH;
    localparam int SEG_W = (MAXL > 1) ? $clog2(MAXL + 1) : 1;

    localparam logic [PW-1:0]    LAST_IDX = PW'(NUM_PHASES - 1);
    localparam logic [SEG_W-1:0] PH_END   = SEG_W'(PHASE_LEN - 1);
    localparam logic [SEG_W-1:0] GAP_END  = SEG_W'(GAP_LEN - 1);
    localparam logic [SEG_W-1:0] STR_END  = SEG_W'(RST_STRETCH - 1);
    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_RST,
        S_STRETCH,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_meta;
    logic                  r_core_rst_n;
    logic [NUM_PHASES-1:0] r_ph_en;
    logic [PW-1:0]         r_idx;
    logic [SEG_W-1:0]      r_seg;
    logic [CNT_W-1:0]      r_cyc;
    logic                  r_done;
    logic                  r_tmo;

    state_t                w_state_n;
    logic                  w_rstn_n;
    logic [NUM_PHASES-1:0] w_ph_n;
    logic [PW-1:0]         w_idx_n;
    logic [PW-1:0]         w_nidx;
    logic [SEG_W-1:0]      w_seg_n;
    logic [CNT_W-1:0]      w_cyc_n;
    logic [CNT_W-1:0]      w_cyc_inc;
    logic                  w_done_n;
    logic                  w_tmo_n;
    logic                  w_run;
    logic                  w_adv;

    // r_meta is the first synchroniser stage; the S_RST->S_STRETCH
    // transition register acts as the second stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_RST;
            r_meta       <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_ph_en      <= '0;
            r_idx        <= '0;
            r_seg        <= '0;
            r_cyc        <= '0;
            r_done       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_meta       <= 1'b1;
            r_core_rst_n <= w_rstn_n;
            r_ph_en      <= w_ph_n;
            r_idx        <= w_idx_n;
            r_seg        <= w_seg_n;
            r_cyc        <= w_cyc_n;
            r_done       <= w_done_n;
            r_tmo        <= w_tmo_n;
        end
    end

    assign w_run     = (r_state == S_ACTIVE) || (r_state == S_GAP);
    assign w_cyc_inc = r_cyc + 1'b1;
    assign w_nidx    = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_rstn_n  = r_core_rst_n;
        w_seg_n   = r_seg;
        w_cyc_n   = r_cyc;
        w_done_n  = r_done;
        w_tmo_n   = r_tmo;
        w_adv     = 1'b0;
        w_idx_n   = r_idx;
        w_ph_n    = '0;

        unique case (r_state)
            S_RST: begin
                if (r_meta) begin
                    w_seg_n = '0;
                    if (RST_STRETCH == 0) begin
                        w_state_n = S_ACTIVE;
                        w_rstn_n  = 1'b1;
                    end else begin
                        w_state_n = S_STRETCH;
                    end
                end
            end
            S_STRETCH: begin
                if (r_seg == STR_END) begin
                    w_state_n = S_ACTIVE;
                    w_rstn_n  = 1'b1;
                    w_seg_n   = '0;
                end else begin
                    w_seg_n = r_seg + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!hold) begin
                    if (r_seg == PH_END) begin
                        w_seg_n = '0;
                        if (GAP_LEN == 0) begin
                            w_adv = 1'b1;
                        end else begin
                            w_state_n = S_GAP;
                        end
                    end else begin
                        w_seg_n = r_seg + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!hold) begin
                    if (r_seg == GAP_END) begin
                        w_state_n = S_ACTIVE;
                        w_seg_n   = '0;
                        w_adv     = 1'b1;
                    end else begin
                        w_seg_n = r_seg + 1'b1;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                w_state_n = S_RST;
            end
        endcase

        // Watchdog and halt override the sequence step on the same edge.
        if (w_run) begin
            w_cyc_n = w_cyc_inc;
            if (w_cyc_inc == TMO_VAL) begin
                w_tmo_n  = 1'b1;
                w_done_n = 1'b1;
            end
            if (halt_req) begin
                w_done_n = 1'b1;
            end
            if (w_done_n) begin
                w_state_n = S_DONE;
                w_seg_n   = r_seg;
                w_adv     = 1'b0;
            end
        end

        if (w_adv) begin
            w_idx_n = w_nidx;
        end

        // hold only acts once the core is out of reset.
        if (w_state_n == S_ACTIVE && !(w_run && hold)) begin
            w_ph_n = NUM_PHASES'(1) << w_idx_n;
        end
    end

`ifdef PIPE_PHASE_ROUND_CNT_EN
    logic [CNT_W-1:0] r_rnd;
    logic             w_wrap;

    assign w_wrap = w_adv && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rnd <= '0;
        end else if (w_wrap && (r_rnd != '1)) begin
            r_rnd <= r_rnd + 1'b1;
        end
    end

    assign round_cnt = r_rnd;
`else
    assign round_cnt = '0;
`endif

    assign core_rst_n = r_core_rst_n;
    assign ph_en      = r_ph_en;
    assign phase_idx  = r_idx;
    assign cycle_cnt  = r_cyc;
    assign done       = r_done;
    assign timeout    = r_tmo;

endmodule

// File: tb/tb_pipe_phase_rst_gen.sv
// tb_pipe_phase_rst_gen: directed and random checks of pipe_phase_rst_gen
// against a position-based reference model.
module tb_pipe_phase_rst_gen;

    localparam int NP  = 2;
    localparam int PL  = 4;
    localparam int GL  = 1;
    localparam int RS  = 4;
    localparam int TO  = 100;
    localparam int CW  = 16;
    localparam int SEG = PL + GL;
    localparam int PER = NP * SEG;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hold = 1'b0;
    logic          halt_req = 1'b0;
    logic          core_rst_n;
    logic [NP-1:0] ph_en;
    logic [0:0]    phase_idx;
    logic [CW-1:0] cycle_cnt;
    logic          done;
    logic          timeout;
    logic [CW-1:0] round_cnt;

    int n_asrt = 0;
    int n_fail = 0;

    // Model: sequence position counts un-held active steps since release.
    int m_edge;
    int m_pos;
    int m_cyc;
    bit m_rstn;
    bit m_done;
    bit m_tmo;
    bit m_hold;

    // Expected ph_en for edges 1..16 after rst release.
    logic [1:0] seq [1:16] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                               2'b01};

    always #5 clk = ~clk;

    pipe_phase_rst_gen #(
        .NUM_PHASES (NP),
        .PHASE_LEN  (PL),
        .GAP_LEN    (GL),
        .RST_STRETCH(RS),
        .TIMEOUT    (TO),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .halt_req  (halt_req),
        .core_rst_n(core_rst_n),
        .ph_en     (ph_en),
        .phase_idx (phase_idx),
        .cycle_cnt (cycle_cnt),
        .done      (done),
        .timeout   (timeout),
        .round_cnt (round_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edge = 0;
        m_pos  = 0;
        m_cyc  = 0;
        m_rstn = 0;
        m_done = 0;
        m_tmo  = 0;
        m_hold = 0;
    endtask

    task automatic model_step(input bit r, input bit h, input bit q);
        if (!r) begin
            model_reset();
        end else if (!m_rstn) begin
            m_edge++;
            if (m_edge == 2 + RS) m_rstn = 1;
        end else if (!m_done) begin
            m_cyc++;
            if (m_cyc == TO) begin
                m_tmo  = 1;
                m_done = 1;
            end
            if (q) m_done = 1;
            m_hold = h;
            if (!m_done && !h) m_pos++;
        end
    endtask

    task automatic check_all(input string tag);
        int slot;
        int pi;
        int e_ph;
        int e_rnd;
        bit act;
        slot = m_pos % PER;
        pi   = slot / SEG;
        act  = (slot % SEG) < PL;
        e_ph = (m_rstn && !m_done && !m_hold && act) ? (1 << pi) : 0;
`ifdef PIPE_PHASE_ROUND_CNT_EN
        e_rnd = m_pos / PER;
`else
        e_rnd = 0;
`endif
        chk({tag, ".rstn"}, 32'(core_rst_n), 32'(m_rstn));
        chk({tag, ".ph_en"}, 32'(ph_en), e_ph);
        chk({tag, ".idx"}, 32'(phase_idx), pi);
        chk({tag, ".cyc"}, 32'(cycle_cnt), m_cyc);
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".tmo"}, 32'(timeout), 32'(m_tmo));
        chk({tag, ".rnd"}, 32'(round_cnt), e_rnd);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step(rst, hold, halt_req);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b0;
        hold     = 1'b0;
        halt_req = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        tick("rst_low");
        tick("rst_low");
        rst = 1'b1;
    endtask

    // Directed check of the first 16 edges after release.
    task automatic release_seq(input string tag);
        for (int e = 1; e <= 16; e++) begin
            tick(tag);
            chk({tag, ".seq_ph"}, 32'(ph_en), 32'(seq[e]));
            chk({tag, ".seq_rstn"}, 32'(core_rst_n), 32'(e >= 2 + RS));
        end
    endtask

    task automatic run_to_cyc(input int target, input string tag);
        for (int i = 0; i < 300 && m_cyc < target && !m_done; i++) begin
            tick(tag);
        end
    endtask

    initial begin
        model_reset();
        #1;
        check_all("por");

        // Release sequence and periodic pattern.
        do_reset();
        release_seq("t1");

        // Hold after two cycles of phase 0.
        do_reset();
        for (int e = 1; e <= 7; e++) tick("t2_pre");
        hold = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick("t2_hold");
            chk("t2.hold_ph", 32'(ph_en), 32'h0);
        end
        hold = 1'b0;
        tick("t2_r1");
        chk("t2.res1", 32'(ph_en), 32'h1);
        tick("t2_r2");
        chk("t2.res2", 32'(ph_en), 32'h1);
        tick("t2_gap");
        chk("t2.gap", 32'(ph_en), 32'h0);
        tick("t2_p1");
        chk("t2.ph1", 32'(ph_en), 32'h2);

        // Watchdog timeout.
        do_reset();
        run_to_cyc(TO + 10, "t3");
        chk("t3.cyc", 32'(cycle_cnt), TO);
        chk("t3.tmo", 32'(timeout), 32'h1);
        chk("t3.done", 32'(done), 32'h1);
        chk("t3.ph", 32'(ph_en), 32'h0);
        for (int e = 0; e < 5; e++) tick("t3_stable");
        chk("t3.cyc_hold", 32'(cycle_cnt), TO);

        // Halt request at cycle_cnt=37.
        do_reset();
        run_to_cyc(37, "t4");
        halt_req = 1'b1;
        tick("t4_halt");
        halt_req = 1'b0;
        chk("t4.done", 32'(done), 32'h1);
        chk("t4.tmo", 32'(timeout), 32'h0);
        chk("t4.cyc", 32'(cycle_cnt), 38);
        chk("t4.ph", 32'(ph_en), 32'h0);
        for (int e = 0; e < 4; e++) tick("t4_frozen");
        chk("t4.cyc_frozen", 32'(cycle_cnt), 38);

        // Halt on the same edge as the watchdog.
        do_reset();
        run_to_cyc(TO - 1, "t4b");
        halt_req = 1'b1;
        tick("t4b_both");
        halt_req = 1'b0;
        chk("t4b.done", 32'(done), 32'h1);
        chk("t4b.tmo", 32'(timeout), 32'h1);
        chk("t4b.cyc", 32'(cycle_cnt), TO);

        // Round counter after 30 active cycles.
        do_reset();
        run_to_cyc(30, "t6");
`ifdef PIPE_PHASE_ROUND_CNT_EN
        chk("t6.rnd", 32'(round_cnt), 3);
`else
        chk("t6.rnd", 32'(round_cnt), 0);
`endif

        // Mid-run asynchronous reset, then identical re-release.
        do_reset();
        run_to_cyc(50, "t5");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t5.async_ph", 32'(ph_en), 32'h0);
        chk("t5.async_rstn", 32'(core_rst_n), 32'h0);
        chk("t5.async_cyc", 32'(cycle_cnt), 32'h0);
        check_all("t5_async");
        do_reset();
        release_seq("t5_rerun");

        // Random hold/halt runs.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int e = 0; e < 160; e++) begin
                tick("rand");
                hold     = ($urandom_range(0, 3) == 0);
                halt_req = ($urandom_range(0, 79) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
